window_h_stream_fp16: RTL
=========================

// Module: window_h_stream_fp16
// PURPOSE
//  Horizontal sliding-window generator placed directly upstream of the box_h convolution wrappers.
//  Converts a raster pixel stream (data/col/row/valid) into a 1 x WINDOW_WIDTH fp16 window centred on each pixel.
//  Edges are zero-padded. Inserts RADIUS flush cycles at end of row, stalling upstream via ready_o.
// PARAMETERS
//  EXP_WIDTH     5    fp exponent bits
//  FRAC_WIDTH    10   fp fraction bits; FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH
//  WINDOW_WIDTH  11   taps; must be odd; RADIUS = (WINDOW_WIDTH-1)/2
//  WINDOW_HEIGHT 1    fixed at 1; present for port-compatibility with convolution_floating_point
//  IMG_WIDTH     640  pixels per row; elaboration error if IMG_WIDTH < WINDOW_WIDTH
//  PAD_VALUE     '0   value driven on out-of-row taps (fp +0.0)
// PORTS
//  clk_i     in   1                    clock
//  rst_i     in   1                    synchronous, active-high reset
//  data_i    in   FP_WIDTH_REG         input pixel
//  col_i     in   16                   pixel column
//  row_i     in   16                   pixel row
//  valid_i   in   1                    pixel present; accepted when valid_i && ready_o
//  ready_o   out  1                    0 during flush and while rst_i is high
//  window_o  out  FP_WIDTH_REG [1][WW] window; [0][0] = col c-RADIUS, [0][WW-1] = col c+RADIUS
//  col_o     out  16                   centre column c
//  row_o     out  16                   centre row
//  valid_o   out  1                    window_o/col_o/row_o valid, single-cycle
//  err_o     out  1                    sticky column-sequence error
// BEHAVIOUR
//  - Reset: window_o all 0, col_o/row_o 0, valid_o 0, err_o 0, state RUN, column counter 0, tap masks 0.
//  - Storage: WW-entry shift register plus a per-tap mask bit. Mask = 1 means the tap holds a real pixel of the current row.
//    On shift, the new entry enters at WW-1 and entry 0 is discarded.
//    window_o[0][k] = mask[k] ? tap[k] : PAD_VALUE. Outputs are registered.
//  - RUN state:
//    - Accepting col_i==0 clears all masks, then shifts in data_i with mask 1, and latches row_i.
//    - Accepting any other column shifts in data_i with mask 1.
//    - Accepting col j with j >= RADIUS gives, on the next cycle, valid_o=1 and col_o=j-RADIUS.
//      Latency is 1 cycle from accepting pixel c+RADIUS to the window for centre c.
//    - Accepting col j < RADIUS produces no output.
//  - FLUSH state:
//    - Entered on the cycle after accepting col IMG_WIDTH-1. ready_o=0 for exactly RADIUS cycles.
//    - Each cycle shifts in PAD_VALUE with mask 0 and emits valid_o=1 for centres IMG_WIDTH-RADIUS .. IMG_WIDTH-1, in order.
//    - After the last flush cycle: state RUN, ready_o=1.
//  - Transitions: RUN -> FLUSH on accepting col IMG_WIDTH-1; FLUSH -> RUN when flush counter reaches RADIUS-1.
//  - valid_i gaps in RUN: no shift, valid_o=0, window state held.
//    valid_i high during FLUSH: not accepted; upstream must hold data_i/col_i/row_i stable.
//  - Column check: expected column = last accepted col + 1, or 0 at row start.
//    An accepted col_i that is neither 0 nor the expected column sets err_o=1 (cleared only by reset).
//    The pixel is still shifted in and the counter resyncs to col_i.
//  - col_i==0 accepted mid-row (before IMG_WIDTH-1): the partial row is abandoned with no flush.
//    Masks are cleared and a new row starts; err_o is not set.
//  - Reset mid-flush: flush aborted; ready_o=1 on the first cycle after rst_i falls; no stale valid_o.
//  - Simultaneous col_i==0 and end-of-row is impossible because IMG_WIDTH >= WW > 1.
//  - row_o holds the row latched at col 0; flush outputs carry that row.
// STRUCTURE
//  - Shared package dfdd_pkg: fp16 typedef (FP_WIDTH_REG), window array typedef, RUN/FLUSH state enum, PAD constant.
//  - Sub-module window_shift_reg: parameterised WW-entry data+mask shift register with enable and clear.
//    Reused later for vertical line windows.
//  - Top level holds the FSM, column and flush counters, the error check, and the output registers.
// TESTING  (WW=11, RADIUS=5, IMG_WIDTH=16; pixel tag data_i = 16'h1000 + 16'h0100*row + col)
//  1. Assert rst_i 3 cycles -> all outputs 0, ready_o 0.
//     First cycle after rst_i falls -> ready_o 1.
//  2. Row 0 streamed back-to-back -> first valid_o 1 cycle after col 5 is accepted, col_o=0.
//     window [0..4]=0, [5..10]=0x1000..0x1005.
//  3. Continue to col 15 -> ready_o=0 for 5 cycles; centres 11..15 emitted.
//     Centre 15 window: [0..4]=0x100A..0x100E, [5]=0x100F, [6..10]=0.
//  4. Row 1 with valid_i toggling 1/0 -> same window values as a back-to-back row, row_o=1.
//     valid_o only on the cycle after each accept; 16 outputs total.
//  5. valid_i held high with row 2 col 0 during flush -> not accepted until ready_o=1.
//     Row 2 col 0 consumed exactly once.
//  6. Columns 0..4 then 7 -> err_o=1 from the cycle after the col-7 accept and stays set.
//     Reset during a flush -> valid_o 0, err_o 0, ready_o 1 after reset.

Source files
------------

// File: rtl/dfdd_pkg.sv
// Shared types for the fp16 window generators.
//   fp16_t         : one half-precision pixel
//   fp16_window_t  : 1 x DEFAULT_WINDOW_WIDTH window of fp16 pixels
//   win_state_t    : sequencing state of the horizontal window generator
//   FP16_PAD       : value presented on taps that fall outside the current row (+0.0)
package dfdd_pkg;

    localparam int FP16_EXP_WIDTH       = 5;
    localparam int FP16_FRAC_WIDTH      = 10;
    localparam int FP16_WIDTH           = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;
    localparam int DEFAULT_WINDOW_WIDTH = 11;

    typedef logic [FP16_WIDTH-1:0] fp16_t;
    typedef fp16_t fp16_window_t [1][DEFAULT_WINDOW_WIDTH];

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } win_state_t;

    localparam fp16_t FP16_PAD = '0;

endpackage

// File: rtl/window_shift_reg.sv
// DEPTH-entry data shift register with a valid mask bit per entry.
//   clk, rst   : clock, synchronous active-high reset (clears data and mask)
//   shift_en   : shift one place; new entry enters at DEPTH-1, entry 0 drops out
//   clear      : zero all mask bits; when combined with shift_en the clear applies
//                to the old entries and the incoming entry still takes data_mask
//   data       : incoming entry
//   data_mask  : mask bit stored with the incoming entry
//   taps, mask : current register contents
module window_shift_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             data_mask,
    output logic [WIDTH-1:0] taps [DEPTH],
    output logic [DEPTH-1:0] mask
);

    logic [DEPTH-2:0] kept_mask;

    assign kept_mask = clear ? '0 : mask[DEPTH-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
            mask <= '0;
        end else begin
            if (shift_en) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    taps[k] <= taps[k+1];
                end
                taps[DEPTH-1] <= data;
                mask          <= {data_mask, kept_mask};
            end else if (clear) begin
                mask <= '0;
            end
        end
    end

endmodule

// File: rtl/window_h_stream_fp16.sv
// Horizontal 1 x WINDOW_WIDTH fp16 sliding window over a raster pixel stream,
// zero-padded at row edges. After the last column of a row it runs RADIUS flush
// cycles (ready_o low) to emit the windows of the last RADIUS centres.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   data_i, col_i, row_i, valid_i: input pixel stream, accepted on valid_i && ready_o
//   ready_o                      : low during flush and while in reset
//   window_o[0][k]               : column c-RADIUS+k of the window centred on c
//   col_o, row_o, valid_o        : centre column/row, single-cycle valid
//   err_o                        : sticky, set on an out-of-sequence non-zero column
//
// state    | meaning
// ST_RUN   | accepting pixels; window emitted once col >= RADIUS has arrived
// ST_FLUSH | RADIUS cycles of pad shifts emitting the last RADIUS centres of the row
module window_h_stream_fp16
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH     = FP16_EXP_WIDTH,
    parameter int FRAC_WIDTH    = FP16_FRAC_WIDTH,
    parameter int WINDOW_WIDTH  = DEFAULT_WINDOW_WIDTH,
    parameter int WINDOW_HEIGHT = 1,
    parameter int IMG_WIDTH     = 640,
    parameter logic [EXP_WIDTH+FRAC_WIDTH:0] PAD_VALUE = FP16_PAD
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   data_i,
    input  logic [15:0]                     col_i,
    input  logic [15:0]                     row_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   window_o [1][WINDOW_WIDTH],
    output logic [15:0]                     col_o,
    output logic [15:0]                     row_o,
    output logic                            valid_o,
    output logic                            err_o
);

    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int RADIUS       = (WINDOW_WIDTH - 1) / 2;
    localparam int CNT_W        = (RADIUS > 1) ? $clog2(RADIUS) : 1;

    localparam logic [CNT_W-1:0] FLUSH_LAST      = CNT_W'(RADIUS - 1);
    localparam logic [15:0]      RADIUS_COL      = 16'(RADIUS);
    localparam logic [15:0]      LAST_COL        = 16'(IMG_WIDTH - 1);
    localparam logic [15:0]      FLUSH_FIRST_COL = 16'(IMG_WIDTH - RADIUS);

    if (WINDOW_WIDTH % 2 == 0 || WINDOW_WIDTH < 3) begin : g_bad_window_width
        $error("WINDOW_WIDTH must be odd and at least 3");
    end
    if (IMG_WIDTH < WINDOW_WIDTH) begin : g_bad_img_width
        $error("IMG_WIDTH must be at least WINDOW_WIDTH");
    end
    if (WINDOW_HEIGHT != 1) begin : g_bad_window_height
        $error("WINDOW_HEIGHT must be 1");
    end

    win_state_t              state;
    win_state_t              state_nxt;
    logic                    flushing;
    logic                    accept;
    logic                    row_start;
    logic                    shift_en;
    logic [FP_WIDTH_REG-1:0] shift_data;
    logic [FP_WIDTH_REG-1:0] taps [WINDOW_WIDTH];
    logic [WINDOW_WIDTH-1:0] tap_mask;
    logic [CNT_W-1:0]        flush_cnt;
    logic [15:0]             col_expect;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (accept && col_i == LAST_COL) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_cnt == FLUSH_LAST)     state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        flushing   = (state == ST_FLUSH);
        ready_o    = !flushing && !rst_i;
        accept     = valid_i && ready_o;
        row_start  = accept && col_i == '0;
        shift_en   = accept || flushing;
        shift_data = flushing ? PAD_VALUE : data_i;
    end

    // Col 0 clears the old row's masks in the same cycle it shifts in, so a
    // partially received row is simply abandoned.
    window_shift_reg #(
        .WIDTH (FP_WIDTH_REG),
        .DEPTH (WINDOW_WIDTH)
    ) u_taps (
        .clk       (clk_i),
        .rst       (rst_i),
        .shift_en  (shift_en),
        .clear     (row_start),
        .data      (shift_data),
        .data_mask (!flushing),
        .taps      (taps),
        .mask      (tap_mask)
    );

    always_comb begin
        for (int k = 0; k < WINDOW_WIDTH; k++) begin
            window_o[0][k] = tap_mask[k] ? taps[k] : PAD_VALUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_cnt  <= '0;
            col_expect <= '0;
            err_o      <= 1'b0;
            valid_o    <= 1'b0;
            col_o      <= '0;
            row_o      <= '0;
        end else begin
            flush_cnt <= (flushing && flush_cnt != FLUSH_LAST) ? flush_cnt + CNT_W'(1) : '0;

            if (accept) begin
                // Resync to whatever column arrived, even when it was out of sequence.
                col_expect <= col_i + 16'd1;
                if (col_i != '0 && col_i != col_expect) begin
                    err_o <= 1'b1;
                end
            end
            if (row_start) begin
                row_o <= row_i;
            end

            valid_o <= flushing || (accept && col_i >= RADIUS_COL);
            if (flushing) begin
                col_o <= FLUSH_FIRST_COL + 16'(flush_cnt);
            end else if (accept && col_i >= RADIUS_COL) begin
                col_o <= col_i - RADIUS_COL;
            end
        end
    end

endmodule
